// File: rtl/en_fire_sched_if.sv
// Launch interface between the enemy fire scheduler and the enemy missile datapath.
// The scheduler (master) drives the launch strobe and coordinates; the missile reports busy.
interface en_fire_sched_if;
  logic        missile_busy;
  logic        fire;
  logic [1:0]  fire_id;
  logic [10:0] x_missile_out;
  logic [10:0] y_missile_out;

  modport master (
    input  missile_busy,
    output fire,
    output fire_id,
    output x_missile_out,
    output y_missile_out
  );

  modport slave (
    output missile_busy,
    input  fire,
    input  fire_id,
    input  x_missile_out,
    input  y_missile_out
  );
endinterface

// File: rtl/en_fire_sched.sv
// Enemy fire scheduler: frame-paced, level-scaled cooldown, then round-robin launch
// over the living enemies of the single shared enemy missile.
module en_fire_sched #(
  parameter logic [7:0]  BASE_COOLDOWN = 8'd120,
  parameter logic [7:0]  LEVEL_STEP    = 8'd10,
  parameter logic [7:0]  MIN_COOLDOWN  = 8'd20,
  parameter logic [10:0] X_OFF         = 11'd24,
  parameter logic [10:0] Y_OFF         = 11'd48
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               enable,
  input  logic               vsync_in,
  input  logic [3:0]         level,
  input  logic [2:0]         alive,
  input  logic [32:0]        en_x,
  input  logic [32:0]        en_y,
  en_fire_sched_if.master    mif
);

  typedef enum logic [1:0] {
    ST_COOLDOWN,
    ST_SELECT,
    ST_LAUNCH
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cd_cnt;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_sel;
  logic [3:0]  r_level_q;
  logic        r_vsync_q;
  logic        r_fire;
  logic [1:0]  r_fire_id;
  logic [10:0] r_x;
  logic [10:0] r_y;

  logic        w_tick;
  logic [11:0] w_prod;
  logic [7:0]  w_floor_gap;
  logic [7:0]  w_reload;
  logic [1:0]  w_next1;
  logic [1:0]  w_next2;
  logic [1:0]  w_sel;
  logic [10:0] w_sel_x;
  logic [10:0] w_sel_y;

  assign w_tick      = vsync_in & ~r_vsync_q;
  assign w_prod      = 12'(level) * 12'(LEVEL_STEP);
  assign w_floor_gap = BASE_COOLDOWN - MIN_COOLDOWN;
  // Product is only narrowed to 8 bits when it is already below the floor gap.
  assign w_reload    = (w_prod >= {4'b0000, w_floor_gap}) ? MIN_COOLDOWN
                                                          : BASE_COOLDOWN - w_prod[7:0];

  assign w_next1 = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
  assign w_next2 = (r_rr_ptr == 2'd0) ? 2'd2 : r_rr_ptr - 2'd1;

  always_comb begin
    w_sel = w_next2;
    if (alive[r_rr_ptr]) begin
      w_sel = r_rr_ptr;
    end else if (alive[w_next1]) begin
      w_sel = w_next1;
    end
  end

  always_comb begin
    w_sel_x = en_x[10:0];
    w_sel_y = en_y[10:0];
    case (w_sel)
      2'd1: begin
        w_sel_x = en_x[21:11];
        w_sel_y = en_y[21:11];
      end
      2'd2: begin
        w_sel_x = en_x[32:22];
        w_sel_y = en_y[32:22];
      end
      default: begin
        w_sel_x = en_x[10:0];
        w_sel_y = en_y[10:0];
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_COOLDOWN;
      r_cd_cnt  <= BASE_COOLDOWN;
      r_rr_ptr  <= 2'd0;
      r_sel     <= 2'd0;
      r_level_q <= 4'd0;
      r_vsync_q <= 1'b0;
      r_fire    <= 1'b0;
      r_fire_id <= 2'd0;
      r_x       <= 11'd0;
      r_y       <= 11'd0;
    end else begin
      r_vsync_q <= vsync_in;
      r_level_q <= level;
      r_fire    <= 1'b0;
      if (!enable) begin
        r_state  <= ST_COOLDOWN;
        r_cd_cnt <= w_reload;
      end else if (level != r_level_q) begin
        // Grace period at every new level, starting again from enemy 1.
        r_state  <= ST_COOLDOWN;
        r_cd_cnt <= w_reload;
        r_rr_ptr <= 2'd0;
      end else begin
        case (r_state)
          ST_COOLDOWN: begin
            if (r_cd_cnt == 8'd0) begin
              r_state <= ST_SELECT;
            end else if (w_tick) begin
              r_cd_cnt <= r_cd_cnt - 8'd1;
            end
          end
          ST_SELECT: begin
            if (!mif.missile_busy && (alive != 3'b000)) begin
              r_sel     <= w_sel;
              r_fire_id <= w_sel + 2'd1;
              r_x       <= w_sel_x + X_OFF;
              r_y       <= w_sel_y + Y_OFF;
              r_state   <= ST_LAUNCH;
            end
          end
          ST_LAUNCH: begin
            r_fire   <= 1'b1;
            r_rr_ptr <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
            r_cd_cnt <= w_reload;
            r_state  <= ST_COOLDOWN;
          end
          default: begin
            r_state <= ST_COOLDOWN;
          end
        endcase
      end
    end
  end

  assign mif.fire          = r_fire;
  assign mif.fire_id       = r_fire_id;
  assign mif.x_missile_out = r_x;
  assign mif.y_missile_out = r_y;

endmodule
